// File: rtl/fpm_pkg.sv
// rtl/fpm_pkg.sv - shared fixed-point widths, pixel limits and accumulator FSM states
// Shared by the multiplier, its feeder and the product accumulator.
package fpm_pkg;

  localparam int PROD_W    = 26;    // sfix26_En18 product width
  localparam int PROD_FRAC = 18;    // fractional bits of a product
  localparam int PIX_W     = 10;    // sfix10_En0 pixel width
  localparam int PIX_MAX   = 511;
  localparam int PIX_MIN   = -512;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_t;

endpackage

// File: rtl/round_saturate.sv
// rtl/round_saturate.sv - round-half-up requantization of an En18 sum to a saturated 10-bit pixel
// Ports:
//   sum   - accumulated sum, signed, PROD_FRAC fractional bits
//   pixel - rounded and clipped pixel, sfix10_En0
//   sat   - 1 when the rounded value fell outside [PIX_MIN, PIX_MAX]
module round_saturate
  import fpm_pkg::*;
#(
  parameter int ACC_W = 30
) (
  input  logic [ACC_W-1:0] sum,
  output logic [PIX_W-1:0] pixel,
  output logic             sat
);

  localparam logic signed [ACC_W:0] W_MAX  = (ACC_W+1)'(PIX_MAX);
  localparam logic signed [ACC_W:0] W_MIN  = (ACC_W+1)'(PIX_MIN);
  localparam logic signed [ACC_W:0] W_HALF = (ACC_W+1)'(1 << (PROD_FRAC - 1));

  logic signed [ACC_W:0] w_wide;
  logic signed [ACC_W:0] w_rnd;
  logic signed [ACC_W:0] w_q;

  // One guard bit so adding the half-LSB can never wrap the sum.
  assign w_wide = $signed({sum[ACC_W-1], sum});
  assign w_rnd  = w_wide + W_HALF;
  assign w_q    = w_rnd >>> PROD_FRAC;

  always_comb begin
    pixel = w_q[PIX_W-1:0];
    sat   = 1'b0;
    if (w_q > W_MAX) begin
      pixel = PIX_W'(PIX_MAX);
      sat   = 1'b1;
    end else if (w_q < W_MIN) begin
      pixel = PIX_W'(PIX_MIN);
      sat   = 1'b1;
    end
  end

endmodule

// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - sums KERNEL_TAPS products per window and holds the requantized pixel
// Ports:
//   clk, GlobalReset          - clock, asynchronous active-high reset
//   ProdValid/ProdPort/ProdReady    - incoming product stream (sfix26_En18)
//   PixelValid/PixelOut/PixelReady  - outgoing pixel stream (sfix10_En0)
//   SatFlag                   - PixelOut was clipped, qualified by PixelValid
module product_accumulator
  import fpm_pkg::*;
#(
  parameter int KERNEL_TAPS = 9,
  parameter int ACC_W       = 30
) (
  input  logic              clk,
  input  logic              GlobalReset,
  input  logic              ProdValid,
  input  logic [PROD_W-1:0] ProdPort,
  output logic              ProdReady,
  output logic              PixelValid,
  input  logic              PixelReady,
  output logic [PIX_W-1:0]  PixelOut,
  output logic              SatFlag
);

  localparam int CNT_W = (KERNEL_TAPS > 1) ? $clog2(KERNEL_TAPS) : 1;
  localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(KERNEL_TAPS - 1);

  acc_state_t r_state;
  acc_state_t w_next;

  logic [CNT_W-1:0] r_count;
  logic [ACC_W-1:0] r_acc;
  logic [PIX_W-1:0] r_pixel;
  logic             r_sat;

  logic             w_accept;
  logic             w_last;
  logic [ACC_W-1:0] w_prod_ext;
  logic [ACC_W-1:0] w_sum;
  logic [PIX_W-1:0] w_pixel;
  logic             w_sat;

  // Acceptance is derived from state directly rather than from ProdReady so
  // the FSM process does not read back one of its own outputs.
  assign w_accept   = ProdValid & ((r_state == ACCUM) | PixelReady);
  assign w_last     = (r_count == LAST_TAP);
  assign w_prod_ext = {{(ACC_W-PROD_W){ProdPort[PROD_W-1]}}, ProdPort};
  // A zero count marks the first tap: load rather than add to the stale sum.
  assign w_sum      = (r_count == '0) ? w_prod_ext : (r_acc + w_prod_ext);

  round_saturate #(
    .ACC_W (ACC_W)
  ) u_round_saturate (
    .sum   (w_sum),
    .pixel (w_pixel),
    .sat   (w_sat)
  );

  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      r_state <= ACCUM;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    ProdReady  = 1'b1;
    PixelValid = 1'b0;
    case (r_state)
      ACCUM: begin
        if (w_accept && w_last) begin
          w_next = HOLD;
        end
      end
      HOLD: begin
        ProdReady  = PixelReady;
        PixelValid = 1'b1;
        // A pop that coincides with a finishing tap refills HOLD at once.
        if (PixelReady && !(w_accept && w_last)) begin
          w_next = ACCUM;
        end
      end
      default: begin
        w_next = ACCUM;
      end
    endcase
  end

  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      r_count <= '0;
      r_acc   <= '0;
      r_pixel <= '0;
      r_sat   <= 1'b0;
    end else if (w_accept) begin
      r_acc <= w_sum;
      if (w_last) begin
        r_count <= '0;
        r_pixel <= w_pixel;
        r_sat   <= w_sat;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign PixelOut = r_pixel;
  assign SatFlag  = r_sat;

endmodule

// File: tb/tb_product_accumulator.sv
// tb/tb_product_accumulator.sv - directed self-checking bench for product_accumulator
module tb_product_accumulator;

  logic        clk;
  logic        GlobalReset;
  logic        ProdValid;
  logic [25:0] ProdPort;
  logic        ProdReady;
  logic        PixelValid;
  logic        PixelReady;
  logic [9:0]  PixelOut;
  logic        SatFlag;

  int checks;
  int failures;

  logic [25:0] vec [9];

  localparam logic [25:0] ONE = 26'd262144;

  product_accumulator #(
    .KERNEL_TAPS (9),
    .ACC_W       (30)
  ) dut (
    .clk         (clk),
    .GlobalReset (GlobalReset),
    .ProdValid   (ProdValid),
    .ProdPort    (ProdPort),
    .ProdReady   (ProdReady),
    .PixelValid  (PixelValid),
    .PixelReady  (PixelReady),
    .PixelOut    (PixelOut),
    .SatFlag     (SatFlag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [25:0] v);
    ProdValid = 1'b1;
    ProdPort  = v;
    tick();
    ProdValid = 1'b0;
    ProdPort  = '0;
  endtask

  task automatic pop();
    PixelReady = 1'b1;
    tick();
    PixelReady = 1'b0;
  endtask

  task automatic run_vec();
    for (int i = 0; i < 9; i++) send(vec[i]);
  endtask

  task automatic fill_vec(input logic [25:0] first, input logic [25:0] rest);
    vec[0] = first;
    for (int i = 1; i < 9; i++) vec[i] = rest;
  endtask

  task automatic test_reset_state();
    GlobalReset = 1'b1;
    ProdValid   = 1'b0;
    ProdPort    = '0;
    PixelReady  = 1'b0;
    tick();
    tick();
    checks++;
    if (PixelValid !== 1'b0 || PixelOut !== 10'd0 || SatFlag !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: valid=%b out=%0d sat=%b, want 0 0 0", PixelValid, PixelOut, SatFlag);
    end
    GlobalReset = 1'b0;
    tick();
    checks++;
    if (ProdReady !== 1'b1 || PixelValid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: ready=%b valid=%b, want 1 0", ProdReady, PixelValid);
    end
  endtask

  task automatic test_unity();
    for (int i = 0; i < 8; i++) send(ONE);
    checks++;
    if (PixelValid !== 1'b0) begin
      failures++;
      $display("FAIL unity_early_valid: valid=%b, want 0 after 8 taps", PixelValid);
    end
    send(ONE);
    checks++;
    if (PixelValid !== 1'b1 || $signed(PixelOut) !== 10'sd9 || SatFlag !== 1'b0) begin
      failures++;
      $display("FAIL unity: valid=%b out=%0d sat=%b, want 1 9 0", PixelValid, $signed(PixelOut), SatFlag);
    end
    checks++;
    if (ProdReady !== 1'b0) begin
      failures++;
      $display("FAIL unity_hold_ready: ready=%b, want 0", ProdReady);
    end
    pop();
    checks++;
    if (PixelValid !== 1'b0 || ProdReady !== 1'b1) begin
      failures++;
      $display("FAIL unity_pop: valid=%b ready=%b, want 0 1", PixelValid, ProdReady);
    end
  endtask

  task automatic test_rounding();
    logic [25:0] inp [4];
    logic [9:0]  exp_pix [4];
    inp[0] = 26'd131072;           exp_pix[0] = 10'd1;
    inp[1] = -26'sd131072;         exp_pix[1] = 10'd0;
    inp[2] = -26'sd196608;         exp_pix[2] = 10'h3FF;
    inp[3] = 26'd65535;            exp_pix[3] = 10'd0;
    for (int k = 0; k < 4; k++) begin
      fill_vec(inp[k], 26'd0);
      run_vec();
      checks++;
      if (PixelValid !== 1'b1 || PixelOut !== exp_pix[k] || SatFlag !== 1'b0) begin
        failures++;
        $display("FAIL rounding[%0d]: valid=%b out=%0d sat=%b, want 1 %0d 0", k, PixelValid,
                 $signed(PixelOut), SatFlag, $signed(exp_pix[k]));
      end
      pop();
    end
  endtask

  task automatic test_saturation();
    logic [25:0] fills [2];
    logic [9:0]  exp_pix [2];
    fills[0] = 26'd26214400;   exp_pix[0] = 10'd511;
    fills[1] = -26'sd26214400; exp_pix[1] = 10'h200;
    for (int k = 0; k < 2; k++) begin
      fill_vec(fills[k], fills[k]);
      run_vec();
      checks++;
      if (PixelValid !== 1'b1 || PixelOut !== exp_pix[k] || SatFlag !== 1'b1) begin
        failures++;
        $display("FAIL sat[%0d]: valid=%b out=%0d sat=%b, want 1 %0d 1", k, PixelValid,
                 $signed(PixelOut), SatFlag, $signed(exp_pix[k]));
      end
      pop();
    end
    // 4 * 127.0 + 3.0 = 511.0 exactly: no clip.
    fill_vec(26'd33292288, 26'd0);
    for (int i = 1; i < 4; i++) vec[i] = 26'd33292288;
    vec[4] = 26'd786432;
    run_vec();
    checks++;
    if (PixelOut !== 10'd511 || SatFlag !== 1'b0) begin
      failures++;
      $display("FAIL sat_exact_max: out=%0d sat=%b, want 511 0", $signed(PixelOut), SatFlag);
    end
    pop();
    // 4 * 127.0 + 3.5 = 511.5 rounds to 512: clip.
    vec[4] = 26'd917504;
    run_vec();
    checks++;
    if (PixelOut !== 10'd511 || SatFlag !== 1'b1) begin
      failures++;
      $display("FAIL sat_half_over: out=%0d sat=%b, want 511 1", $signed(PixelOut), SatFlag);
    end
    pop();
    // 4 * -128.0 = -512.0 exactly: no clip.
    fill_vec(-26'sd33554432, 26'd0);
    for (int i = 1; i < 4; i++) vec[i] = -26'sd33554432;
    run_vec();
    checks++;
    if (PixelOut !== 10'h200 || SatFlag !== 1'b0) begin
      failures++;
      $display("FAIL sat_exact_min: out=%0d sat=%b, want -512 0", $signed(PixelOut), SatFlag);
    end
    pop();
  endtask

  task automatic test_gaps();
    // 9 taps of 0.5 with idle cycles between them: 4.5 rounds to 5.
    for (int i = 0; i < 9; i++) begin
      send(26'd131072);
      if (i < 8) begin
        tick();
        tick();
      end
    end
    checks++;
    if (PixelValid !== 1'b1 || PixelOut !== 10'd5 || SatFlag !== 1'b0) begin
      failures++;
      $display("FAIL gaps: valid=%b out=%0d sat=%b, want 1 5 0", PixelValid, $signed(PixelOut), SatFlag);
    end
    pop();
  endtask

  task automatic test_backpressure();
    fill_vec(ONE, ONE);
    run_vec();
    PixelReady = 1'b0;
    ProdValid  = 1'b1;
    ProdPort   = 26'd524288;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (ProdReady !== 1'b0 || PixelValid !== 1'b1 || PixelOut !== 10'd9) begin
        failures++;
        $display("FAIL backpressure[%0d]: ready=%b valid=%b out=%0d, want 0 1 9", c, ProdReady,
                 PixelValid, $signed(PixelOut));
      end
      @(posedge clk);
      #1;
    end
    PixelReady = 1'b1;
    #1;
    checks++;
    if (ProdReady !== 1'b1) begin
      failures++;
      $display("FAIL backpressure_release_ready: ready=%b, want 1", ProdReady);
    end
    tick();
    PixelReady = 1'b0;
    ProdValid  = 1'b0;
    checks++;
    if (PixelValid !== 1'b0) begin
      failures++;
      $display("FAIL backpressure_pop: valid=%b, want 0", PixelValid);
    end
    // The product taken on the pop cycle was tap 1, so 8 more finish the window.
    for (int i = 0; i < 8; i++) send(26'd524288);
    checks++;
    if (PixelValid !== 1'b1 || PixelOut !== 10'd18 || SatFlag !== 1'b0) begin
      failures++;
      $display("FAIL back_to_back: valid=%b out=%0d sat=%b, want 1 18 0", PixelValid,
               $signed(PixelOut), SatFlag);
    end
    pop();
  endtask

  task automatic test_reset_in_hold();
    fill_vec(ONE, ONE);
    run_vec();
    #2;
    GlobalReset = 1'b1;
    #1;
    checks++;
    if (PixelValid !== 1'b0 || PixelOut !== 10'd0 || SatFlag !== 1'b0) begin
      failures++;
      $display("FAIL reset_async: valid=%b out=%0d sat=%b, want 0 0 0", PixelValid, $signed(PixelOut), SatFlag);
    end
    tick();
    GlobalReset = 1'b0;
    tick();
    tick();
    checks++;
    if (ProdReady !== 1'b1 || PixelValid !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold_drop: ready=%b valid=%b, want 1 0", ProdReady, PixelValid);
    end
  endtask

  task automatic test_mid_window_reset();
    for (int i = 0; i < 4; i++) send(ONE);
    #2;
    GlobalReset = 1'b1;
    #1;
    tick();
    GlobalReset = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) send(26'd524288);
    checks++;
    if (PixelValid !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_early: valid=%b, want 0 after 8 taps", PixelValid);
    end
    send(26'd524288);
    checks++;
    if (PixelValid !== 1'b1 || PixelOut !== 10'd18 || SatFlag !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: valid=%b out=%0d sat=%b, want 1 18 0", PixelValid, $signed(PixelOut), SatFlag);
    end
    pop();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset_state();
    test_unity();
    test_rounding();
    test_saturation();
    test_gaps();
    test_backpressure();
    test_reset_in_hold();
    test_mid_window_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 The block SHALL have parameter KERNEL_TAPS, default 9, meaning the number of products summed per output pixel (legal range 1..64).
REQ-002 The block SHALL have parameter ACC_W, default 30, meaning the accumulator width; the required minimum is 26 + clog2(KERNEL_TAPS).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port GlobalReset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port ProdValid, input, 1 bit: ProdPort holds a valid product this cycle.
REQ-006 The block SHALL have port ProdPort, input, 26 bits: multiplier product, sfix26_En18.
REQ-007 The block SHALL have port ProdReady, output, 1 bit: the block accepts ProdPort this cycle.
REQ-008 The block SHALL have port PixelValid, output, 1 bit: PixelOut holds a completed result.
REQ-009 The block SHALL have port PixelReady, input, 1 bit: the downstream consumer takes PixelOut this cycle.
REQ-010 The block SHALL have port PixelOut, output, 10 bits: requantized result, sfix10_En0.
REQ-011 The block SHALL have port SatFlag, output, 1 bit: PixelOut was clipped; qualified by PixelValid.

Function
REQ-012 A product SHALL be accepted only on a cycle where ProdValid and ProdReady are both 1.
REQ-013 The FSM SHALL have exactly two states: ACCUM and HOLD.
REQ-014 In ACCUM, ProdReady SHALL be 1 and PixelValid SHALL be 0.
REQ-015 In HOLD, PixelValid SHALL be 1 and ProdReady SHALL equal PixelReady (combinational).
REQ-016 On an accepted product, the accumulator SHALL sign-extend ProdPort to ACC_W and add it.
REQ-017 On an accepted product, the tap counter SHALL increment.
REQ-018 The first tap of a window SHALL load the accumulator with the product, not add to the previous sum.
REQ-019 When the accepted product is tap KERNEL_TAPS, the block SHALL register PixelOut and SatFlag from the final sum, clear the counter and enter HOLD on the next edge.
REQ-020 Latency from the accepted final tap to PixelValid=1 SHALL be exactly 1 cycle.
REQ-021 Requantization SHALL compute r = (sum + 2^17) >>> 18 (arithmetic shift; round half toward +infinity).
REQ-022 Requantization SHALL saturate r to [-512, 511] and set SatFlag=1 if and only if clipping occurred.
REQ-023 In HOLD, PixelOut and SatFlag SHALL remain stable until PixelReady=1.
REQ-024 In HOLD with PixelReady=1 and no accepted product, the block SHALL return to ACCUM.
REQ-025 In HOLD with PixelReady=1 and an accepted product, that product SHALL start the next window with no lost cycle.
REQ-026 With KERNEL_TAPS=1, each accepted product SHALL complete a window; in HOLD with a simultaneous pop, the block SHALL stay in HOLD with the new result, sustaining 1 pixel per cycle.
REQ-027 A cycle with ProdValid=0 SHALL leave the accumulator and counter unchanged; gaps within a window are legal.
REQ-028 The accumulator SHALL never wrap, given ACC_W at or above the minimum in REQ-002.

Reset
REQ-029 While GlobalReset=1, the block SHALL force state ACCUM, counter 0, accumulator 0, PixelOut 0, SatFlag 0 and PixelValid 0.
REQ-030 Reset mid-window SHALL discard the partial sum, so the next accepted product is tap 1.
REQ-031 Reset in HOLD SHALL drop the pending pixel without asserting PixelValid afterward.
REQ-032 Reset assertion SHALL be asynchronous, and deassertion SHALL take effect at the next clk edge.

Structure
REQ-033 Package fpm_pkg SHALL hold PROD_W=26, PROD_FRAC=18, PIX_W=10, PIX_MAX=511, PIX_MIN=-512 and the FSM state enum; these are shared with the multiplier and its feeder.
REQ-034 The rounding and saturation logic SHALL be a combinational sub-module round_saturate (inputs: sum; outputs: pixel and sat).
REQ-035 All other logic SHALL be in product_accumulator.

Verification
REQ-036 Reset check: assert GlobalReset mid-run -> all outputs 0 immediately; after release, ProdReady=1 and PixelValid=0.
REQ-037 Unity sum: 9 products of 262144 (1.0) -> PixelOut=9, SatFlag=0, PixelValid one cycle after the 9th accept.
REQ-038 Rounding cases, each a window of one product plus 8 zeros:
  - 131072 -> 1
  - -131072 -> 0
  - -196608 -> -1
  - 65535 -> 0
REQ-039 Saturation cases:
  - 9 products of 26214400 (100.0) -> 511, SatFlag=1
  - 9 products of -26214400 -> -512, SatFlag=1
  - sum exactly 511.0 -> 511, SatFlag=0
REQ-040 Backpressure: hold PixelReady=0 for 5 cycles in HOLD -> ProdReady=0 and PixelOut stable; when PixelReady=1 with ProdValid=1, the product is accepted as tap 1 of the next window in that same cycle.
REQ-041 Mid-window reset: 4 taps of 1.0, then reset, then 9 taps of 2.0 -> PixelOut=18.
